// File: rtl/quad_gen.sv
// Quadrature step generator: emits Gray-coded {a,b} steps at a programmable rate
// with a one-entry command queue and a signed position count.
module quad_gen #(
    parameter int MIN_PERIOD = 4,
    parameter int POS_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [7:0]       cmd_steps,
    input  logic [7:0]       cmd_period,
    output logic [1:0]       q,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
);

    localparam logic [7:0]       MIN_P8  = MIN_PERIOD[7:0];
    localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_state_next;
    logic             r_init;
    logic             r_pend_v, r_pend_dir;
    logic [7:0]       r_pend_steps, r_pend_per;
    logic             r_act_dir;
    logic [7:0]       r_act_steps, r_act_per, r_cnt;
    logic [1:0]       r_phase, r_q;
    logic [POS_W-1:0] r_pos;
    logic             r_done;

    logic       w_accept, w_step, w_last;
    logic       w_load_cmd, w_load_pend, w_to_pend, w_done_next;
    logic [7:0] w_eff_per;
    logic [1:0] w_phase_next;

    assign w_accept     = cmd_valid & cmd_ready;
    assign w_eff_per    = (cmd_period < MIN_P8) ? MIN_P8 : cmd_period;
    assign w_step       = (r_state == RUN) && (r_cnt == 8'd0);
    assign w_last       = w_step && (r_act_steps == 8'd1);
    assign w_phase_next = r_act_dir ? r_phase + 2'd1 : r_phase - 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_load_cmd) w_state_next = RUN;
            RUN:  if (w_last && !w_load_cmd && !w_load_pend) w_state_next = IDLE;
        endcase
    end

    // A new command arriving on the final-step edge chains straight into RUN
    // without a done pulse; a zero-step command anywhere just produces done.
    always_comb begin
        w_load_cmd  = 1'b0;
        w_load_pend = 1'b0;
        w_to_pend   = 1'b0;
        w_done_next = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (cmd_steps != 8'd0) w_load_cmd  = 1'b1;
                    else                   w_done_next = 1'b1;
                end
            end
            RUN: begin
                if (w_last) begin
                    if (r_pend_v) begin
                        if (r_pend_steps != 8'd0) w_load_pend = 1'b1;
                        else                      w_done_next = 1'b1;
                    end else if (w_accept && (cmd_steps != 8'd0)) begin
                        w_load_cmd = 1'b1;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end else if (w_accept) begin
                    w_to_pend = 1'b1;
                end
            end
        endcase
    end

    assign cmd_ready = r_init & ~r_pend_v;
    assign busy      = (r_state == RUN);
    assign done      = r_done;
    assign q         = r_q;
    assign position  = r_pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init       <= 1'b0;
            r_pend_v     <= 1'b0;
            r_pend_dir   <= 1'b0;
            r_pend_steps <= '0;
            r_pend_per   <= '0;
            r_act_dir    <= 1'b0;
            r_act_steps  <= '0;
            r_act_per    <= '0;
            r_cnt        <= '0;
            r_phase      <= '0;
            r_q          <= '0;
            r_pos        <= '0;
            r_done       <= 1'b0;
        end else begin
            r_init <= 1'b1;
            r_done <= w_done_next;

            if (w_load_cmd) begin
                r_act_dir   <= cmd_dir;
                r_act_steps <= cmd_steps;
                r_act_per   <= w_eff_per;
                r_cnt       <= w_eff_per - 8'd1;
            end else if (w_load_pend) begin
                r_act_dir   <= r_pend_dir;
                r_act_steps <= r_pend_steps;
                r_act_per   <= r_pend_per;
                r_cnt       <= r_pend_per - 8'd1;
            end else if (w_step) begin
                r_act_steps <= r_act_steps - 8'd1;
                r_cnt       <= r_act_per - 8'd1;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt - 8'd1;
            end

            if (w_step) begin
                r_phase <= w_phase_next;
                r_q     <= {w_phase_next[1], w_phase_next[0] ^ w_phase_next[1]};
                r_pos   <= r_act_dir ? r_pos + POS_ONE : r_pos - POS_ONE;
            end

            if (w_to_pend) begin
                r_pend_v     <= 1'b1;
                r_pend_dir   <= cmd_dir;
                r_pend_steps <= cmd_steps;
                r_pend_per   <= w_eff_per;
            end else if (w_last) begin
                r_pend_v <= 1'b0;
            end
        end
    end

endmodule
